// File: rtl/inst_seq_control_pkg.sv
// Shared types and helpers for the instruction sequencer: FSM state encoding
// and bit-offset helpers for the packed per-loop configuration vectors.
package inst_seq_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Low bit of field idx in a vector of equal-width fields packed from bit 0.
  function automatic int slot_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/inst_seq_control_if.sv
// Handshake, instruction-write and instruction-fetch bundle between the
// CSR/config side (master) and the sequencer (slave).
interface inst_seq_control_if #(
  parameter int RegAddrWidth = 32
);

  logic                    start_i;
  logic                    stall_i;
  logic                    busy_o;
  logic                    done_o;
  logic [RegAddrWidth-1:0] inst_wr_addr_i;
  logic [RegAddrWidth-1:0] inst_wr_data_i;
  logic                    inst_wr_en_i;
  logic                    inst_wr_err_o;
  logic [RegAddrWidth-1:0] inst_pc_o;
  logic [RegAddrWidth-1:0] inst_rd_o;
  logic                    dbg_en_i;
  logic [RegAddrWidth-1:0] dbg_addr_i;
  logic                    dbg_step_i;

  modport master (
    output start_i, stall_i, inst_wr_addr_i, inst_wr_data_i, inst_wr_en_i,
           dbg_en_i, dbg_addr_i, dbg_step_i,
    input  busy_o, done_o, inst_wr_err_o, inst_pc_o, inst_rd_o
  );

  modport slave (
    input  start_i, stall_i, inst_wr_addr_i, inst_wr_data_i, inst_wr_en_i,
           dbg_en_i, dbg_addr_i, dbg_step_i,
    output busy_o, done_o, inst_wr_err_o, inst_pc_o, inst_rd_o
  );

endinterface

// File: rtl/inst_seq_control_loop_stack.sv
// Nested hardware-loop iteration counters with priority scan and cascaded
// exit: loops sharing an end address unwind together in one advance.
module inst_loop_stack
  import inst_seq_pkg::*;
#(
  parameter int NumLoops         = 4,
  parameter int LoopCountWidth   = 16,
  parameter int InstMemAddrWidth = 8,
  parameter int LoopModeWidth    = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clr_i,
  input  logic                                 init_i,
  input  logic                                 advance_i,
  input  logic [InstMemAddrWidth-1:0]          pc_i,
  input  logic [LoopModeWidth-1:0]             loop_mode_i,
  input  logic [NumLoops*InstMemAddrWidth-1:0] jump_addr_i,
  input  logic [NumLoops*InstMemAddrWidth-1:0] end_addr_i,
  input  logic [NumLoops*LoopCountWidth-1:0]   count_i,
  output logic                                 jump_o,
  output logic [InstMemAddrWidth-1:0]          jump_addr_o,
  output logic                                 last_o
);

  logic [LoopCountWidth-1:0] cnt_q [NumLoops];
  logic [LoopCountWidth-1:0] cnt_d [NumLoops];
  logic [LoopCountWidth-1:0] limit;
  logic                      taken;

  // cnt_q[i] counts completed body passes; jump back while another pass is owed.
  always_comb begin
    taken       = 1'b0;
    jump_addr_o = '0;
    limit       = '0;
    for (int i = 0; i < NumLoops; i++) cnt_d[i] = cnt_q[i];
    for (int i = 0; i < NumLoops; i++) begin
      if (!taken && (i < int'(loop_mode_i)) &&
          (end_addr_i[slot_lo(i, InstMemAddrWidth) +: InstMemAddrWidth] == pc_i)) begin
        limit = count_i[slot_lo(i, LoopCountWidth) +: LoopCountWidth];
        if (limit != '0) limit = limit - LoopCountWidth'(1);
        if (cnt_q[i] < limit) begin
          cnt_d[i]    = cnt_q[i] + LoopCountWidth'(1);
          taken       = 1'b1;
          jump_addr_o = jump_addr_i[slot_lo(i, InstMemAddrWidth) +: InstMemAddrWidth];
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NumLoops; i++) cnt_q[i] <= '0;
    end else if (clr_i || init_i) begin
      for (int i = 0; i < NumLoops; i++) cnt_q[i] <= '0;
    end else if (advance_i) begin
      for (int i = 0; i < NumLoops; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign jump_o = taken;
  assign last_o = !taken;

endmodule

// File: rtl/reg_file_1w1r.sv
// One-write, one-combinational-read register file with synchronous clear.
// A same-cycle write and read of one address returns the previous contents.
module reg_file_1w1r #(
  parameter int DataWidth = 32,
  parameter int Depth     = 256,
  parameter int AddrWidth = $clog2(Depth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < Depth; i++) mem[i] <= '0;
    end else if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/inst_seq_control.sv
// Instruction sequencer: walks the PC over instruction memory with nested
// zero-overhead loops, a start/busy/done handshake and debug single-step.
module inst_seq_control
  import inst_seq_pkg::*;
#(
  parameter int RegAddrWidth     = 32,
  parameter int InstMemDepth     = 256,
  parameter int NumLoops         = 4,
  parameter int LoopCountWidth   = 16,
  parameter int InstMemAddrWidth = $clog2(InstMemDepth),
  parameter int LoopModeWidth    = $clog2(NumLoops + 1)
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clr_i,
  inst_seq_control_if.slave                    bus,
  input  logic [RegAddrWidth-1:0]              prog_end_addr_i,
  input  logic [LoopModeWidth-1:0]             loop_mode_i,
  input  logic [NumLoops*InstMemAddrWidth-1:0] loop_jump_addr_i,
  input  logic [NumLoops*InstMemAddrWidth-1:0] loop_end_addr_i,
  input  logic [NumLoops*LoopCountWidth-1:0]   loop_count_i
);

  state_t                      state;
  logic [InstMemAddrWidth-1:0] pc;
  logic [InstMemAddrWidth-1:0] rd_addr;
  logic [InstMemAddrWidth-1:0] jump_addr;
  logic                        run, advance, init, at_end, jump, last;
  logic                        mem_we, wr_err;
  logic                        unused_hi;

  assign run     = (state == ST_RUN);
  assign init    = (state == ST_IDLE) && bus.start_i;
  // Stall wins over a debug step; with debug off the PC free-runs.
  assign advance = run && !bus.stall_i && (!bus.dbg_en_i || bus.dbg_step_i);
  assign at_end  = (pc == prog_end_addr_i[InstMemAddrWidth-1:0]);

  inst_loop_stack #(
    .NumLoops        (NumLoops),
    .LoopCountWidth  (LoopCountWidth),
    .InstMemAddrWidth(InstMemAddrWidth),
    .LoopModeWidth   (LoopModeWidth)
  ) u_loop_stack (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (clr_i),
    .init_i     (init),
    .advance_i  (advance),
    .pc_i       (pc),
    .loop_mode_i(loop_mode_i),
    .jump_addr_i(loop_jump_addr_i),
    .end_addr_i (loop_end_addr_i),
    .count_i    (loop_count_i),
    .jump_o     (jump),
    .jump_addr_o(jump_addr),
    .last_o     (last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= ST_IDLE;
      pc     <= '0;
      wr_err <= 1'b0;
    end else if (clr_i) begin
      state  <= ST_IDLE;
      pc     <= '0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= run && bus.inst_wr_en_i;
      case (state)
        ST_IDLE: begin
          if (bus.start_i) begin
            state <= ST_RUN;
            pc    <= '0;
          end
        end
        ST_RUN: begin
          if (advance) begin
            if (jump)        pc    <= jump_addr;
            else if (at_end) state <= ST_DONE;
            else             pc    <= pc + InstMemAddrWidth'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mem_we  = bus.inst_wr_en_i && !run;
  assign rd_addr = bus.dbg_en_i ? bus.dbg_addr_i[InstMemAddrWidth-1:0] : pc;

  reg_file_1w1r #(
    .DataWidth(RegAddrWidth),
    .Depth    (InstMemDepth)
  ) u_inst_mem (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr_i),
    .we_i   (mem_we),
    .waddr_i(bus.inst_wr_addr_i[InstMemAddrWidth-1:0]),
    .wdata_i(bus.inst_wr_data_i),
    .raddr_i(rd_addr),
    .rdata_o(bus.inst_rd_o)
  );

  assign bus.busy_o        = run;
  assign bus.done_o        = (state == ST_DONE);
  assign bus.inst_wr_err_o = wr_err;
  assign bus.inst_pc_o     = RegAddrWidth'(pc);

  // Only the low address bits select a memory word.
  assign unused_hi = ^{prog_end_addr_i[RegAddrWidth-1:InstMemAddrWidth],
                       bus.inst_wr_addr_i[RegAddrWidth-1:InstMemAddrWidth],
                       bus.dbg_addr_i[RegAddrWidth-1:InstMemAddrWidth]};

endmodule

// File: tb/tb_inst_seq_control.sv
// Self-checking bench for inst_seq_control: directed scenarios plus random
// nested-loop programs compared against an instruction-level reference model.
module tb_inst_seq_control;

  localparam int NL = 4;
  localparam int AW = 8;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic [31:0]      prog_end = '0;
  logic [2:0]       loop_mode = '0;
  logic [NL*AW-1:0] loop_jump = '0;
  logic [NL*AW-1:0] loop_end = '0;
  logic [NL*CW-1:0] loop_count = '0;

  int vectors = 0;
  int miscompares = 0;

  inst_seq_control_if #(.RegAddrWidth(32)) bus ();

  inst_seq_control #(
    .RegAddrWidth  (32),
    .InstMemDepth  (256),
    .NumLoops      (NL),
    .LoopCountWidth(CW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .clr_i           (clr),
    .bus             (bus),
    .prog_end_addr_i (prog_end),
    .loop_mode_i     (loop_mode),
    .loop_jump_addr_i(loop_jump),
    .loop_end_addr_i (loop_end),
    .loop_count_i    (loop_count)
  );

  always #5 clk = ~clk;

  // Reference state: memory image, loop config, expected and observed traces.
  logic [31:0] mem_m [256];
  int m_jump [NL];
  int m_end  [NL];
  int m_cnt  [NL];
  int m_mode, m_pend;
  int exp_pc [$];
  int obs_pc [$];
  int exp_seq [$];
  int run_cycles;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Program order as described: a loop body of count N runs N times (0 as 1);
  // when a body ends without another pass owed, outer loops ending there are tried.
  function automatic void build_trace();
    int pc;
    int passes [NL];
    int n;
    bit jumped;
    pc = 0;
    for (int i = 0; i < NL; i++) passes[i] = 0;
    exp_pc.delete();
    for (int step = 0; step < 4000; step++) begin
      exp_pc.push_back(pc);
      jumped = 0;
      for (int i = 0; i < m_mode && !jumped; i++) begin
        if (m_end[i] == pc) begin
          n = (m_cnt[i] == 0) ? 1 : m_cnt[i];
          if (passes[i] + 1 < n) begin
            passes[i]++;
            pc = m_jump[i];
            jumped = 1;
          end else begin
            passes[i] = 0;
          end
        end
      end
      if (!jumped) begin
        if (pc == m_pend) break;
        pc = (pc + 1) % 256;
      end
    end
  endfunction

  task automatic apply_cfg();
    prog_end  = 32'(m_pend);
    loop_mode = 3'(m_mode);
    for (int i = 0; i < NL; i++) begin
      loop_jump[i*AW +: AW]  = 8'(m_jump[i]);
      loop_end[i*AW +: AW]   = 8'(m_end[i]);
      loop_count[i*CW +: CW] = 16'(m_cnt[i]);
    end
  endtask

  task automatic set_loop(input int i, input int j, input int e, input int c);
    m_jump[i] = j;
    m_end[i]  = e;
    m_cnt[i]  = c;
  endtask

  task automatic write_mem(input int a, input logic [31:0] d);
    bus.inst_wr_en_i   = 1'b1;
    bus.inst_wr_addr_i = {24'($urandom), 8'(a)};
    bus.inst_wr_data_i = d;
    @(negedge clk);
    bus.inst_wr_en_i = 1'b0;
    mem_m[a] = d;
  endtask

  // Starts from IDLE at a negedge and returns at the negedge where DONE is seen.
  task automatic run_prog(input string tag, input int stall_pct);
    int k, cycles;
    bit st;
    build_trace();
    apply_cfg();
    obs_pc.delete();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    k = 0;
    cycles = 0;
    while (k < exp_pc.size() && cycles < 10000) begin
      check({tag, " busy"}, 32'(bus.busy_o), 32'd1);
      check({tag, " done"}, 32'(bus.done_o), 32'd0);
      check({tag, " pc"}, bus.inst_pc_o, 32'(exp_pc[k]));
      check({tag, " rd"}, bus.inst_rd_o, mem_m[exp_pc[k]]);
      st = ($urandom_range(99) < stall_pct);
      bus.stall_i = st;
      if (!st) begin
        obs_pc.push_back(int'(bus.inst_pc_o));
        k++;
      end
      cycles++;
      @(negedge clk);
    end
    bus.stall_i = 1'b0;
    check({tag, " budget"}, 32'(cycles < 10000), 32'd1);
    check({tag, " done pulse"}, 32'(bus.done_o), 32'd1);
    check({tag, " busy low"}, 32'(bus.busy_o), 32'd0);
    run_cycles = cycles;
  endtask

  task automatic finish_done(input string tag);
    @(negedge clk);
    check({tag, " done cleared"}, 32'(bus.done_o), 32'd0);
    check({tag, " idle"}, 32'(bus.busy_o), 32'd0);
  endtask

  task automatic check_seq(input string tag);
    check({tag, " len"}, 32'(obs_pc.size()), 32'(exp_seq.size()));
    for (int i = 0; i < exp_seq.size() && i < obs_pc.size(); i++)
      check($sformatf("%s seq[%0d]", tag, i), 32'(obs_pc[i]), 32'(exp_seq[i]));
  endtask

  initial begin
    logic [31:0] d;
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    for (int i = 0; i < NL; i++) set_loop(i, 0, 0, 0);
    m_mode = 0;
    m_pend = 0;
    bus.start_i = 0; bus.stall_i = 0; bus.inst_wr_en_i = 0;
    bus.inst_wr_addr_i = '0; bus.inst_wr_data_i = '0;
    bus.dbg_en_i = 0; bus.dbg_addr_i = '0; bus.dbg_step_i = 0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst busy", 32'(bus.busy_o), 32'd0);
    check("rst done", 32'(bus.done_o), 32'd0);
    check("rst err", 32'(bus.inst_wr_err_o), 32'd0);
    check("rst pc", bus.inst_pc_o, 32'd0);
    check("rst rd", bus.inst_rd_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int a = 0; a < 48; a++) write_mem(a, $urandom);

    // Same-cycle write and read returns old data
    bus.dbg_en_i = 1'b1;
    bus.dbg_addr_i = {24'hABCDEF, 8'd41};
    bus.inst_wr_en_i = 1'b1;
    bus.inst_wr_addr_i = 32'd41;
    d = $urandom;
    bus.inst_wr_data_i = d;
    #1 check("raw old", bus.inst_rd_o, mem_m[41]);
    @(negedge clk);
    bus.inst_wr_en_i = 1'b0;
    mem_m[41] = d;
    check("raw new", bus.inst_rd_o, d);
    bus.dbg_en_i = 1'b0;
    bus.dbg_addr_i = '0;

    // Straight line, with stray loop config beyond loop_mode
    m_mode = 0; m_pend = 5;
    set_loop(0, 0, 2, 3);
    run_prog("line", 0);
    exp_seq = '{0, 1, 2, 3, 4, 5};
    check_seq("line");
    check("line run cycles", 32'(run_cycles), 32'd6);
    // Write while DONE is accepted
    d = $urandom;
    bus.inst_wr_en_i = 1'b1; bus.inst_wr_addr_i = 32'd40; bus.inst_wr_data_i = d;
    @(negedge clk);
    bus.inst_wr_en_i = 1'b0;
    mem_m[40] = d;
    check("line done cleared", 32'(bus.done_o), 32'd0);
    check("done write no err", 32'(bus.inst_wr_err_o), 32'd0);
    bus.dbg_en_i = 1'b1; bus.dbg_addr_i = 32'd40;
    #1 check("done write data", bus.inst_rd_o, d);
    bus.dbg_en_i = 1'b0; bus.dbg_addr_i = '0;

    // Single loop; loop1 shares the end address but is outside loop_mode
    m_mode = 1; m_pend = 6;
    set_loop(0, 2, 4, 3);
    set_loop(1, 0, 4, 3);
    run_prog("loop1", 0);
    exp_seq = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 5, 6};
    check_seq("loop1");
    finish_done("loop1");

    // Cascaded nested loops sharing an end address
    m_mode = 2; m_pend = 4;
    set_loop(0, 2, 3, 2);
    set_loop(1, 1, 3, 2);
    run_prog("casc", 0);
    exp_seq = '{0, 1, 2, 3, 2, 3, 1, 2, 3, 2, 3, 4};
    check_seq("casc");
    // start while DONE is ignored
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    check("start in done", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    check("start in done idle", 32'(bus.busy_o), 32'd0);

    exp_seq = '{0, 1, 2, 3, 1, 2, 3, 4};
    set_loop(0, 2, 3, 1);
    run_prog("casc c1", 0);
    check_seq("casc c1");
    finish_done("casc c1");
    set_loop(0, 2, 3, 0);
    run_prog("casc c0", 0);
    check_seq("casc c0");
    finish_done("casc c0");

    // Stall, debug read and single-step, write guard
    m_mode = 0; m_pend = 8;
    apply_cfg();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("dbg pc3", bus.inst_pc_o, 32'd3);
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("stall hold %0d", i), bus.inst_pc_o, 32'd3);
    end
    bus.stall_i = 1'b0;
    bus.dbg_en_i = 1'b1;
    bus.dbg_addr_i = {24'h5A5A5A, 8'd10};
    #1 check("dbg read", bus.inst_rd_o, mem_m[10]);
    @(negedge clk);
    check("dbg freeze", bus.inst_pc_o, 32'd3);
    bus.stall_i = 1'b1; bus.dbg_step_i = 1'b1;
    @(negedge clk);
    check("stall beats step", bus.inst_pc_o, 32'd3);
    bus.stall_i = 1'b0;
    @(negedge clk);
    check("step1", bus.inst_pc_o, 32'd4);
    bus.dbg_step_i = 1'b0;
    @(negedge clk);
    check("step1 hold", bus.inst_pc_o, 32'd4);
    bus.dbg_step_i = 1'b1;
    @(negedge clk);
    check("step2", bus.inst_pc_o, 32'd5);
    bus.dbg_step_i = 1'b0;
    bus.inst_wr_en_i = 1'b1; bus.inst_wr_addr_i = 32'd6; bus.inst_wr_data_i = ~mem_m[6];
    @(negedge clk);
    bus.inst_wr_en_i = 1'b0;
    check("run write err", 32'(bus.inst_wr_err_o), 32'd1);
    check("step2 hold", bus.inst_pc_o, 32'd5);
    @(negedge clk);
    check("run write err pulse", 32'(bus.inst_wr_err_o), 32'd0);
    bus.dbg_en_i = 1'b0; bus.dbg_addr_i = '0;
    @(negedge clk);
    check("resume pc6", bus.inst_pc_o, 32'd6);
    check("run write dropped", bus.inst_rd_o, mem_m[6]);
    @(negedge clk);
    check("resume pc7", bus.inst_pc_o, 32'd7);
    @(negedge clk);
    check("resume pc8", bus.inst_pc_o, 32'd8);
    @(negedge clk);
    check("dbg done", 32'(bus.done_o), 32'd1);
    finish_done("dbg");

    // Clear mid-loop
    m_mode = 1; m_pend = 6;
    set_loop(0, 2, 4, 3);
    apply_cfg();
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (6) @(negedge clk);
    check("clr pre pc", bus.inst_pc_o, 32'd3);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 256; i++) mem_m[i] = '0;
    check("clr busy", 32'(bus.busy_o), 32'd0);
    check("clr pc", bus.inst_pc_o, 32'd0);
    check("clr done", 32'(bus.done_o), 32'd0);
    bus.dbg_en_i = 1'b1; bus.dbg_addr_i = 32'd10;
    #1 check("clr mem", bus.inst_rd_o, 32'd0);
    bus.dbg_en_i = 1'b0; bus.dbg_addr_i = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check($sformatf("clr no done %0d", i), 32'(bus.done_o), 32'd0);
    end
    for (int a = 0; a < 4; a++) write_mem(a, $urandom);
    run_prog("clr rerun", 0);
    exp_seq = '{0, 1, 2, 3, 4, 2, 3, 4, 2, 3, 4, 5, 6};
    check_seq("clr rerun");
    finish_done("clr rerun");

    // Random properly nested programs with random stalls
    for (int a = 0; a < 32; a++) write_mem(a, $urandom);
    for (int p = 0; p < 8; p++) begin
      int lo, hi;
      m_mode = $urandom_range(0, 4);
      for (int i = 0; i < NL; i++)
        set_loop(i, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
      lo = 1; hi = 14;
      for (int i = m_mode - 1; i >= 0; i--) begin
        m_jump[i] = $urandom_range(lo, hi);
        m_end[i]  = ($urandom_range(1) == 1) ? hi : $urandom_range(m_jump[i], hi);
        m_cnt[i]  = $urandom_range(0, 3);
        lo = m_jump[i];
        hi = m_end[i];
      end
      m_pend = $urandom_range(15, 24);
      run_prog($sformatf("rand%0d", p), 25);
      finish_done($sformatf("rand%0d", p));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

endmodule
